// File: rtl/v_mem_wport_arb.sv
// Write-port arbiter: init-engine writes take priority, functional writes are queued and drained when init is idle.
// Optional stall counter enabled by defining V_MEM_WPORT_ARB_STALL_CNT_EN.
module v_mem_wport_arb #(
    parameter int N     = 64,
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_init_wen_r,
    input  logic [$clog2(N)-1:0]  i_init_waddr_r,
    input  logic [W-1:0]          i_init_wdata_r,
    input  logic                  i_init_busy_r,
    input  logic                  i_wr_vld,
    input  logic [$clog2(N)-1:0]  i_wr_addr,
    input  logic [W-1:0]          i_wr_data,
    output logic                  o_wr_rdy,
    output logic                  o_mem_wen_r,
    output logic [$clog2(N)-1:0]  o_mem_waddr_r,
    output logic [W-1:0]          o_mem_wdata_r,
    output logic                  o_busy_r,
    output logic [15:0]           o_stall_cnt_r
);

    localparam int AW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_INIT  = 2'd1,
        GNT_DRAIN = 2'd2
    } gnt_t;

    logic [AW-1:0] r_q_addr [DEPTH];
    logic [W-1:0]  r_q_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    gnt_t          w_gnt;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic [CW-1:0] w_count_next;
    logic          w_mem_wen_next;
    logic [AW-1:0] w_mem_waddr_next;
    logic [W-1:0]  w_mem_wdata_next;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == {CW{1'b0}});
    // Ready depends only on the registered count, never on a same-cycle dequeue.
    assign o_wr_rdy = ~rst & ~w_full;
    assign w_enq    = i_wr_vld & o_wr_rdy;
    assign w_deq    = (w_gnt == GNT_DRAIN);
    assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

    // Grant selection: init first, queue only while the init engine is fully idle.
    always_comb begin
        w_gnt = GNT_IDLE;
        if (i_init_wen_r) begin
            w_gnt = GNT_INIT;
        end else if (!i_init_busy_r && !w_empty) begin
            w_gnt = GNT_DRAIN;
        end else begin
            w_gnt = GNT_IDLE;
        end
    end

    // Next values for the memory write port; address/data hold when idle.
    always_comb begin
        w_mem_wen_next   = 1'b0;
        w_mem_waddr_next = o_mem_waddr_r;
        w_mem_wdata_next = o_mem_wdata_r;
        case (w_gnt)
            GNT_INIT: begin
                w_mem_wen_next   = 1'b1;
                w_mem_waddr_next = i_init_waddr_r;
                w_mem_wdata_next = i_init_wdata_r;
            end
            GNT_DRAIN: begin
                w_mem_wen_next   = 1'b1;
                w_mem_waddr_next = r_q_addr[r_rd_ptr];
                w_mem_wdata_next = r_q_data[r_rd_ptr];
            end
            default: begin
                w_mem_wen_next   = 1'b0;
                w_mem_waddr_next = o_mem_waddr_r;
                w_mem_wdata_next = o_mem_wdata_r;
            end
        endcase
    end

    // Queue storage; enqueue is already blocked during reset via o_wr_rdy.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_addr[r_wr_ptr] <= i_wr_addr;
            r_q_data[r_wr_ptr] <= i_wr_data;
        end
    end

    // Queue control and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= {PW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_count       <= {CW{1'b0}};
            o_mem_wen_r   <= 1'b0;
            o_mem_waddr_r <= {AW{1'b0}};
            o_mem_wdata_r <= {W{1'b0}};
            o_busy_r      <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1'b1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            r_count       <= w_count_next;
            o_mem_wen_r   <= w_mem_wen_next;
            o_mem_waddr_r <= w_mem_waddr_next;
            o_mem_wdata_r <= w_mem_wdata_next;
            o_busy_r      <= i_init_busy_r | (w_count_next != {CW{1'b0}});
        end
    end

`ifdef V_MEM_WPORT_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where a functional write is refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (i_wr_vld && !o_wr_rdy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign o_stall_cnt_r = r_stall_cnt;
`else
    assign o_stall_cnt_r = 16'h0000;
`endif

endmodule
